// File: rtl/leitor_sequencia.sv
// leitor_sequencia: read side of the LED-sequence memory. Fetches one 64-bit word per
// address and plays it as num_codigos LED codes (LSB code first), each held for
// ciclos_passo cycles. Never writes the memory.
module leitor_sequencia #(
  parameter int bits_palavra  = 64,
  parameter int end_registros = 10,
  parameter int bits_led      = 2,
  parameter int num_codigos   = 32,
  parameter int ciclos_passo  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inicio,
  input  logic                     cancelar,
  input  logic [end_registros-1:0] end_inicial,
  input  logic [end_registros:0]   num_palavras,
  output logic [end_registros-1:0] mem_endereco,
  output logic                     mem_hab_escrita,
  input  logic [bits_palavra-1:0]  mem_dado,
  output logic [bits_led-1:0]      led_codigo,
  output logic                     led_valido,
  output logic [4:0]               indice_led,
  output logic                     ocupado,
  output logic                     concluido
);

  localparam int PW = (ciclos_passo > 1) ? $clog2(ciclos_passo) : 1;
  localparam logic [PW-1:0] ULT_PASSO  = PW'(ciclos_passo - 1);
  localparam logic [4:0]    ULT_INDICE = 5'(num_codigos - 1);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] LE      = 3'd1;
  localparam logic [2:0] CAPTURA = 3'd2;
  localparam logic [2:0] EXIBE   = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

  logic [2:0]               estado;
  logic [bits_palavra-1:0]  deslocador;
  logic [PW-1:0]            passo;
  logic [end_registros:0]   restantes;

  // Sequencer: fetch, capture and play each word; cancelar pre-empts every advance
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      mem_endereco <= '0;
      deslocador   <= '0;
      indice_led   <= '0;
      passo        <= '0;
      restantes    <= '0;
    end else if (cancelar && estado != OCIOSO) begin
      estado <= OCIOSO;
    end else begin
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            if (num_palavras != '0) begin
              mem_endereco <= end_inicial;
              restantes    <= num_palavras;
              estado       <= LE;
            end else begin
              estado <= FIM;
            end
          end
        end
        LE: estado <= CAPTURA;
        CAPTURA: begin
          deslocador <= mem_dado;
          indice_led <= '0;
          passo      <= '0;
          estado     <= EXIBE;
        end
        EXIBE: begin
          if (passo == ULT_PASSO) begin
            if (indice_led != ULT_INDICE) begin
              deslocador <= deslocador >> bits_led;
              indice_led <= indice_led + 5'd1;
              passo      <= '0;
            end else if (restantes > (end_registros+1)'(1)) begin
              restantes    <= restantes - 1'b1;
              mem_endereco <= mem_endereco + 1'b1;
              estado       <= LE;
            end else begin
              estado <= FIM;
            end
          end else begin
            passo <= passo + 1'b1;
          end
        end
        FIM: estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Outputs decoded from state; the code tracks the shifter so it holds outside EXIBE
  always_comb begin
    mem_hab_escrita = 1'b0;
    led_codigo      = deslocador[bits_led-1:0];
    led_valido      = (estado == EXIBE);
    ocupado         = (estado != OCIOSO);
    concluido       = (estado == FIM);
  end

endmodule

// File: tb/tb_leitor_sequencia.sv
// Directed bench for leitor_sequencia with a synchronous-read memory model.
module tb_leitor_sequencia;

  logic        clock = 1'b0;
  logic        reset;
  logic        inicio;
  logic        cancelar;
  logic [9:0]  end_inicial;
  logic [10:0] num_palavras;
  logic [9:0]  mem_endereco;
  logic        mem_hab_escrita;
  logic [63:0] mem_dado;
  logic [1:0]  led_codigo;
  logic        led_valido;
  logic [4:0]  indice_led;
  logic        ocupado;
  logic        concluido;

  logic [63:0] mem [0:1023];

  int n_total = 0;
  int n_pass  = 0;
  int conc_cnt = 0;
  int val_cnt  = 0;
  int we_bad   = 0;

  always #5 clock = ~clock;

  leitor_sequencia #(
    .bits_palavra (64),
    .end_registros(10),
    .bits_led     (2),
    .num_codigos  (32),
    .ciclos_passo (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inicio         (inicio),
    .cancelar       (cancelar),
    .end_inicial    (end_inicial),
    .num_palavras   (num_palavras),
    .mem_endereco   (mem_endereco),
    .mem_hab_escrita(mem_hab_escrita),
    .mem_dado       (mem_dado),
    .led_codigo     (led_codigo),
    .led_valido     (led_valido),
    .indice_led     (indice_led),
    .ocupado        (ocupado),
    .concluido      (concluido)
  );

  // synchronous-read memory: data valid one cycle after the address
  always @(posedge clock) mem_dado <= mem[mem_endereco];

  // event monitors sampled mid-cycle
  always @(negedge clock) begin
    if (concluido === 1'b1) conc_cnt <= conc_cnt + 1;
    if (led_valido === 1'b1) val_cnt <= val_cnt + 1;
    if (mem_hab_escrita !== 1'b0) we_bad <= we_bad + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // pulse inicio for one edge; returns just after that edge
  task automatic start(input logic [9:0] addr, input logic [10:0] n);
    end_inicial  = addr;
    num_palavras = n;
    inicio       = 1'b1;
    tick();
    inicio       = 1'b0;
    end_inicial  = 10'h2AA;
    num_palavras = 11'h155;
  endtask

  // play ncodes codes of word w from the first EXIBE cycle; optionally pulse inicio at code pulse_idx
  task automatic run_codes(input logic [63:0] w, input logic [9:0] addr,
                           input int ncodes, input int pulse_idx);
    logic [63:0] t;
    for (int i = 0; i < ncodes; i++) begin
      t = w >> (2 * i);
      for (int p = 0; p < 4; p++) begin
        check("led_valido", {63'd0, led_valido}, 64'd1);
        check("led_codigo", {62'd0, led_codigo}, {62'd0, t[1:0]});
        if (p == 0) begin
          check("indice_led", {59'd0, indice_led}, i);
          check("mem_endereco", {54'd0, mem_endereco}, {54'd0, addr});
        end
        if (i == pulse_idx && p == 0) inicio = 1'b1;
        tick();
        inicio = 1'b0;
      end
    end
  endtask

  // LE then CAPTURA: two dark cycles before the word plays
  task automatic fetch_gap(input logic [9:0] addr);
    check("gap_le_valido", {63'd0, led_valido}, 64'd0);
    check("gap_le_addr", {54'd0, mem_endereco}, {54'd0, addr});
    tick();
    check("gap_cap_valido", {63'd0, led_valido}, 64'd0);
    check("gap_cap_ocupado", {63'd0, ocupado}, 64'd1);
    tick();
  endtask

  task automatic expect_fim();
    check("fim_concluido", {63'd0, concluido}, 64'd1);
    check("fim_valido", {63'd0, led_valido}, 64'd0);
    check("fim_ocupado", {63'd0, ocupado}, 64'd1);
    tick();
    check("after_fim_concluido", {63'd0, concluido}, 64'd0);
    check("after_fim_ocupado", {63'd0, ocupado}, 64'd0);
  endtask

  int c0;
  int v0;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 64'd0;
    mem[5]    = 64'hE4E4_E4E4_E4E4_E4E4;
    mem[6]    = 64'h1B1B_1B1B_1B1B_1B1B;
    mem[7]    = 64'h0123_4567_89AB_CDEF;
    mem[1023] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[0]    = 64'd0;

    reset = 1'b1; inicio = 1'b0; cancelar = 1'b0;
    end_inicial = '0; num_palavras = '0;
    tick(); tick();
    check("rst_addr", {54'd0, mem_endereco}, 64'd0);
    check("rst_codigo", {62'd0, led_codigo}, 64'd0);
    check("rst_indice", {59'd0, indice_led}, 64'd0);
    check("rst_valido", {63'd0, led_valido}, 64'd0);
    check("rst_ocupado", {63'd0, ocupado}, 64'd0);
    check("rst_concluido", {63'd0, concluido}, 64'd0);
    check("rst_we", {63'd0, mem_hab_escrita}, 64'd0);
    // reset overrides inicio
    inicio = 1'b1; num_palavras = 11'd1; tick(); inicio = 1'b0;
    check("rst_beats_inicio", {63'd0, ocupado}, 64'd0);
    reset = 1'b0;
    tick();

    // 1: single word, 0,1,2,3 repeating
    c0 = conc_cnt;
    start(10'd5, 11'd1);
    check("t1_ocupado", {63'd0, ocupado}, 64'd1);
    fetch_gap(10'd5);
    run_codes(mem[5], 10'd5, 32, -1);
    expect_fim();
    check("t1_hold_codigo", {62'd0, led_codigo}, 64'd3);
    check("t1_hold_indice", {59'd0, indice_led}, 64'd31);
    tick();
    check("t1_conc_count", conc_cnt - c0, 64'd1);

    // 2: two words across the address wrap
    c0 = conc_cnt;
    start(10'd1023, 11'd2);
    fetch_gap(10'd1023);
    run_codes(64'hFFFF_FFFF_FFFF_FFFF, 10'd1023, 32, -1);
    check("t2_wrap_addr", {54'd0, mem_endereco}, 64'd0);
    fetch_gap(10'd0);
    run_codes(64'd0, 10'd0, 32, -1);
    expect_fim();
    tick();
    check("t2_conc_count", conc_cnt - c0, 64'd1);

    // 3: zero words -> straight to FIM, no read
    c0 = conc_cnt; v0 = val_cnt;
    start(10'd9, 11'd0);
    check("t3_addr_unchanged", {54'd0, mem_endereco}, 64'd0);
    expect_fim();
    tick(); tick();
    check("t3_conc_count", conc_cnt - c0, 64'd1);
    check("t3_never_valid", val_cnt - v0, 64'd0);

    // 4: inicio while busy is ignored
    c0 = conc_cnt;
    start(10'd5, 11'd1);
    fetch_gap(10'd5);
    run_codes(mem[5], 10'd5, 32, 10);
    expect_fim();
    tick(); tick();
    check("t4_conc_count", conc_cnt - c0, 64'd1);
    check("t4_idle", {63'd0, ocupado}, 64'd0);

    // 5: cancelar at code 7, then restart
    c0 = conc_cnt;
    start(10'd5, 11'd1);
    fetch_gap(10'd5);
    run_codes(mem[5], 10'd5, 7, -1);
    check("t5_at_idx7", {59'd0, indice_led}, 64'd7);
    cancelar = 1'b1; tick(); cancelar = 1'b0;
    check("t5_ocupado", {63'd0, ocupado}, 64'd0);
    check("t5_valido", {63'd0, led_valido}, 64'd0);
    check("t5_addr_hold", {54'd0, mem_endereco}, 64'd5);
    check("t5_codigo_hold", {62'd0, led_codigo}, 64'd3);
    check("t5_indice_hold", {59'd0, indice_led}, 64'd7);
    tick(); tick();
    check("t5_no_conc", conc_cnt - c0, 64'd0);
    cancelar = 1'b1; tick();
    check("t5_cancel_idle_noeffect", {63'd0, ocupado}, 64'd0);
    cancelar = 1'b0;
    start(10'd1023, 11'd1);
    fetch_gap(10'd1023);
    run_codes(64'hFFFF_FFFF_FFFF_FFFF, 10'd1023, 32, -1);
    expect_fim();
    check("t5_restart_conc", conc_cnt - c0, 64'd1);

    // inicio and cancelar together in OCIOSO: inicio wins, cancel next cycle
    cancelar = 1'b1;
    start(10'd6, 11'd2);
    check("both_ocupado", {63'd0, ocupado}, 64'd1);
    check("both_addr", {54'd0, mem_endereco}, 64'd6);
    tick();
    cancelar = 1'b0;
    check("both_cancelled", {63'd0, ocupado}, 64'd0);

    // 6: reset during word 2 of 3
    c0 = conc_cnt;
    start(10'd5, 11'd3);
    fetch_gap(10'd5);
    run_codes(mem[5], 10'd5, 32, -1);
    fetch_gap(10'd6);
    run_codes(mem[6], 10'd6, 5, -1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_addr", {54'd0, mem_endereco}, 64'd0);
    check("t6_codigo", {62'd0, led_codigo}, 64'd0);
    check("t6_indice", {59'd0, indice_led}, 64'd0);
    check("t6_valido", {63'd0, led_valido}, 64'd0);
    check("t6_ocupado", {63'd0, ocupado}, 64'd0);
    check("t6_concluido", {63'd0, concluido}, 64'd0);
    tick(); tick();
    check("t6_stays_idle", {63'd0, ocupado}, 64'd0);
    check("t6_no_conc", conc_cnt - c0, 64'd0);

    check("we_never_high", we_bad, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
